tcm_mp_controller: RTL

Multi-port, parametrised tightly-coupled memory controller: NPORT bus masters (e.g. instruction fetch, data, DMA) share one single-ported word array through a round-robin arbiter. It adds a configurable array depth, a configurable read latency of 1 or 2 cycles, per-port write permission, and address-range faulting. It sits between the core/DMA bus ports and the on-chip TCM array, at the same point in the address map as the single-port TCM controller.

---
 rtl/tcm_mp_controller_pkg.sv | 45 ++++
 rtl/tcm_rr_arbiter.sv | 42 ++++
 rtl/tcm_mp_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tcm_mp_controller_pkg.sv
// Shared bus constants, pipeline stage record and byte-lane helpers for the
// multi-port TCM controller.
package tcm_mp_controller_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int BUS_ACC_CNT   = 3;
  localparam int TCM_VA_WIDTH  = 16;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // One in-flight transaction; data is only meaningful past the first stage.
  typedef struct packed {
    logic                     vld;
    logic                     w_rb;
    logic [1:0]               port;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [1:0]               off;
    logic [BUS_WIDTH-1:0]     data;
  } tcm_stage_t;

  function automatic logic [3:0] lane_mask(input logic [BUS_ACC_WIDTH-1:0] acc,
                                           input logic [1:0] off);
    case (acc)
      BUS_ACC_1B: return 4'b0001 << off;
      BUS_ACC_2B: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [BUS_WIDTH-1:0] align_rd(input logic [BUS_WIDTH-1:0] word,
                                                    input logic [BUS_ACC_WIDTH-1:0] acc,
                                                    input logic [1:0] off);
    logic [BUS_WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (acc)
      BUS_ACC_1B: return {24'b0, sh[7:0]};
      BUS_ACC_2B: return {16'b0, sh[15:0]};
      default:    return sh;
    endcase
  endfunction

endpackage

// File: rtl/tcm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible port at or after
// the pointer; the pointer advances past each winner and holds when idle.
module tcm_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] elig,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win;
  logic          hit;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    win = ptr_reg;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && elig[idx]) begin
        gnt[idx] = 1'b1;
        hit      = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_reg <= '0;
    end else if (hit) begin
      ptr_reg <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/tcm_mp_controller.sv
// Multi-port TCM controller: NPORT masters share one word array through a
// round-robin arbiter, with per-port fault decode and an RD_LAT-deep response pipe.
module tcm_mp_controller
  import tcm_mp_controller_pkg::*;
#(
  parameter int               VA_WIDTH = TCM_VA_WIDTH,
  parameter int               DEPTH    = 1 << (VA_WIDTH - 2),
  parameter int               NPORT    = 2,
  parameter int               RD_LAT   = 1,
  parameter logic [NPORT-1:0] WR_EN    = {NPORT{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NPORT*VA_WIDTH-1:0]  addr,
  input  logic [NPORT-1:0]           w_rb,
  input  logic [NPORT*BUS_ACC_WIDTH-1:0] acc,
  input  logic [NPORT*BUS_WIDTH-1:0] wdata,
  input  logic [NPORT-1:0]           req,
  output logic [NPORT*BUS_WIDTH-1:0] rdata,
  output logic [NPORT-1:0]           resp,
  output logic [NPORT-1:0]           fault
);

  localparam int AWX = VA_WIDTH - 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NPORT-1:0] invld;
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] gnt;
  logic [NPORT-1:0] busy_reg;

  genvar gi;

  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_dec
      logic [VA_WIDTH-1:0]      a;
      logic [BUS_ACC_WIDTH-1:0] sz;
      logic                     misal;
      logic                     oor;
      logic                     wr_deny;

      assign a       = addr[gi*VA_WIDTH +: VA_WIDTH];
      assign sz      = acc[gi*BUS_ACC_WIDTH +: BUS_ACC_WIDTH];
      assign misal   = (a[0] && (sz != BUS_ACC_1B)) ||
                       ((a[1:0] != 2'b00) && (sz == BUS_ACC_4B));
      assign oor     = {1'b0, a[VA_WIDTH-1:2]} >= AWX'(DEPTH);
      assign wr_deny = w_rb[gi] & ~WR_EN[gi];
      assign invld[gi] = misal | oor | wr_deny;
      assign fault[gi] = req[gi] & invld[gi];
      assign elig[gi]  = req[gi] & ~invld[gi] & ~busy_reg[gi];
    end
  endgenerate

  tcm_rr_arbiter #(
    .N (NPORT)
  ) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .elig (elig),
    .gnt  (gnt)
  );

  // Winning port's request attributes.
  logic                     g_vld;
  logic [1:0]               g_port;
  logic [1:0]               g_off;
  logic [IW-1:0]            g_idx;
  logic                     g_wrb;
  logic [BUS_ACC_WIDTH-1:0] g_acc;
  logic [BUS_WIDTH-1:0]     g_wdata;

  always_comb begin
    g_vld   = 1'b0;
    g_port  = '0;
    g_off   = '0;
    g_idx   = '0;
    g_wrb   = 1'b0;
    g_acc   = '0;
    g_wdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt[i]) begin
        g_vld   = 1'b1;
        g_port  = 2'(i);
        g_off   = addr[i*VA_WIDTH +: 2];
        g_idx   = addr[i*VA_WIDTH+2 +: IW];
        g_wrb   = w_rb[i];
        g_acc   = acc[i*BUS_ACC_WIDTH +: BUS_ACC_WIDTH];
        g_wdata = wdata[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Array: byte-lane write, registered read. Writes are suppressed while in reset.
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [BUS_WIDTH-1:0] rd_word_reg;
  logic [3:0]           wr_lane;
  logic [BUS_WIDTH-1:0] wr_data;
  logic                 rd_en;

  assign wr_lane = lane_mask(g_acc, g_off) & {4{g_vld & g_wrb & rstn}};
  assign wr_data = g_wdata << {g_off, 3'b000};
  assign rd_en   = g_vld & ~g_wrb;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_lane[b]) mem[g_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    if (rd_en) rd_word_reg <= mem[g_idx];
  end

  // Response pipeline; the first stage's data comes straight from the array register.
  tcm_stage_t st_reg [RD_LAT];
  tcm_stage_t st_in;
  tcm_stage_t head;
  tcm_stage_t tail;

  always_comb begin
    st_in      = '0;
    st_in.vld  = g_vld;
    st_in.w_rb = g_wrb;
    st_in.port = g_port;
    st_in.acc  = g_acc;
    st_in.off  = g_off;
  end

  always_comb begin
    head      = st_reg[0];
    head.data = align_rd(rd_word_reg, st_reg[0].acc, st_reg[0].off);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < RD_LAT; k++) st_reg[k] <= '0;
    end else begin
      st_reg[0] <= st_in;
      for (int k = 1; k < RD_LAT; k++) st_reg[k] <= (k == 1) ? head : st_reg[k-1];
    end
  end

  generate
    if (RD_LAT == 1) begin : g_tail1
      assign tail = head;
    end else begin : g_tailn
      assign tail = st_reg[RD_LAT-1];
    end
  endgenerate

  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_resp
      logic [BUS_WIDTH-1:0] rdata_reg;
      logic                 rd_hit;

      assign resp[gi] = rstn & tail.vld & (tail.port == 2'(gi));
      assign rd_hit   = resp[gi] & ~tail.w_rb;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          rdata_reg <= '0;
        end else if (rd_hit) begin
          rdata_reg <= tail.data;
        end
      end

      // Completing read data is visible in the same cycle as resp.
      assign rdata[gi*BUS_WIDTH +: BUS_WIDTH] = rd_hit ? tail.data : rdata_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg | gnt) & ~resp;
    end
  end

endmodule
